trng_uart_rx: RTL and testbench

- UART receiver: the far end of the TRNG serial link; deserialises the 8N1 stream that TRNG drives on UART_Tx.
- Used in the verification harness and the planned loopback/self-test path to recover random bytes.
- Presents bytes through a small show-ahead FIFO with a valid/ready handshake.
- Reports framing, overrun and (optionally) parity errors.

---
 rtl/trng_uart_rx.sv | 264 ++++++++++++++++++++++++++
 tb/tb_trng_uart_rx.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/trng_uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : trng_uart_rx
// Purpose  : 8N1 UART receiver for the TRNG serial link. A 2-flop
//            synchroniser feeds a mid-bit sampling FSM. Bytes are delivered
//            through a show-ahead FIFO with a valid/ready handshake.
//            Framing and overrun errors are reported as one-cycle pulses.
// Options  : `define TRNG_RX_PARITY_EN selects 8E1 framing and adds the
//            parity_err output.
// Revision : 1.0 - initial release
// ============================================================================
module trng_uart_rx #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       TRNG_Clock,
  input  logic       TRNG_Enable,
  input  logic       UART_Rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
`ifdef TRNG_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       rx_busy
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int HALF         = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam int FCNT_W       = PTR_W + 1;

  localparam logic [CNT_W-1:0]  CNT_HALF_M1 = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [FCNT_W-1:0] FIFO_FULL   = FCNT_W'(FIFO_DEPTH);

`ifdef TRNG_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd4
  } state_t;
`endif

  // --------------------------------------------------------------------------
  // Input synchroniser: the line idles high, so reset the flops to 1 to avoid
  // a false start bit coming out of reset.
  // --------------------------------------------------------------------------
  logic rx_meta;
  logic rx_s;

  // Two-flop synchroniser for the asynchronous serial line
  always_ff @(posedge TRNG_Clock or posedge TRNG_Enable) begin
    if (TRNG_Enable) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= UART_Rx;
      rx_s    <= rx_meta;
    end
  end

  // --------------------------------------------------------------------------
  // Receive FSM
  // --------------------------------------------------------------------------
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shift, shift_n;
  logic             push;
  logic             ferr_n;
  logic             perr_n;
  logic             par_bad;

`ifdef TRNG_RX_PARITY_EN
  logic par_bit, par_n;
  // Even parity: the parity bit must equal the XOR of the data bits
  assign par_bad = par_bit ^ (^shift);
`else
  assign par_bad = 1'b0;
`endif

  // FSM state register and bit-timing counters
  always_ff @(posedge TRNG_Clock or posedge TRNG_Enable) begin
    if (TRNG_Enable) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
`ifdef TRNG_RX_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
`ifdef TRNG_RX_PARITY_EN
      par_bit <= par_n;
`endif
    end
  end

  // Next-state logic: sample mid-start, then once per bit period after that
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    push      = 1'b0;
    ferr_n    = 1'b0;
    perr_n    = 1'b0;
`ifdef TRNG_RX_PARITY_EN
    par_n     = par_bit;
`endif
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rx_s) begin
          state_n = START;
        end
      end
      START: begin
        if (cnt == CNT_HALF_M1) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          // A line that is high again at mid-start was only a glitch
          state_n   = rx_s ? IDLE : DATA;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_n            = '0;
          shift_n[bit_idx] = rx_s;
          bit_idx_n        = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef TRNG_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
`ifdef TRNG_RX_PARITY_EN
      PARITY: begin
        if (cnt == CNT_LAST) begin
          cnt_n   = '0;
          par_n   = rx_s;
          state_n = STOP;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
`endif
      STOP: begin
        if (cnt == CNT_LAST) begin
          // Leave at mid-stop so a following start edge is not missed
          cnt_n   = '0;
          state_n = IDLE;
          push    = rx_s & ~par_bad;
          ferr_n  = ~rx_s;
          perr_n  = par_bad;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign rx_busy = (state != IDLE);

  // --------------------------------------------------------------------------
  // Show-ahead receive FIFO
  // --------------------------------------------------------------------------
  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [FCNT_W-1:0] count;
  logic              full;
  logic              pop;
  logic              wr_en;

  assign full     = (count == FIFO_FULL);
  assign rx_valid = (count != '0);
  assign pop      = rx_valid & rx_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept
  assign wr_en    = push & (~full | pop);
  assign rx_data  = rx_valid ? mem[rd_ptr] : 8'h00;

  // Storage array; contents are only observable through rx_valid
  always_ff @(posedge TRNG_Clock) begin
    if (wr_en) begin
      mem[wr_ptr] <= shift;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at a power-of-two depth
  always_ff @(posedge TRNG_Clock or posedge TRNG_Enable) begin
    if (TRNG_Enable) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({wr_en, pop})
        2'b10:   count <= count + FCNT_W'(1);
        2'b01:   count <= count - FCNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Registered one-cycle error pulses, aligned with the cycle after the stop sample
  always_ff @(posedge TRNG_Clock or posedge TRNG_Enable) begin
    if (TRNG_Enable) begin
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
`ifdef TRNG_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err  <= ferr_n;
      overrun    <= push & full & ~pop;
`ifdef TRNG_RX_PARITY_EN
      parity_err <= perr_n;
`endif
    end
  end

`ifndef TRNG_RX_PARITY_EN
  // perr_n only drives a port in the parity build
  logic unused_perr;
  assign unused_perr = perr_n;
`endif

endmodule
`default_nettype wire

// File: tb/tb_trng_uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_trng_uart_rx
// Purpose  : Self-checking bench for trng_uart_rx at default parameters.
//            Expected bytes are queued when a frame is driven and compared
//            when the receiver presents them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trng_uart_rx;

  localparam int CPB = 50000000 / 115200;  // 434 clocks per bit

  logic       clk = 1'b0;
  logic       rst;
  logic       line;
  logic       ready;
  logic [7:0] data;
  logic       valid;
  logic       ferr;
  logic       ovr;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;
  int fe_cnt   = 0;
  int ov_cnt   = 0;
  logic [7:0] exp_q[$];

  trng_uart_rx dut (
    .TRNG_Clock (clk),
    .TRNG_Enable(rst),
    .UART_Rx    (line),
    .rx_data    (data),
    .rx_valid   (valid),
    .rx_ready   (ready),
    .frame_err  (ferr),
    .overrun    (ovr),
    .rx_busy    (busy)
  );

  always #5 clk = ~clk;

  // Count every cycle an error pulse is high, so pulse width is visible too
  always @(negedge clk) begin
    if (ferr === 1'b1) fe_cnt++;
    if (ovr === 1'b1) ov_cnt++;
  end

  // Hold the line for one bit period; entered and left at posedge+1
  task automatic drive_bit(input logic v);
    line = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input logic good);
    if (good) exp_q.push_back(b);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
    line = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; line = 1'b1; ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid); else n_pass++;
    n_checks++; if (data !== 8'h00) $display("FAIL reset_data: got %h want 00", data); else n_pass++;
    n_checks++; if (ferr !== 1'b0) $display("FAIL reset_ferr: got %b want 0", ferr); else n_pass++;
    n_checks++; if (ovr !== 1'b0) $display("FAIL reset_ovr: got %b want 0", ovr); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    @(posedge clk); #1 rst = 1'b0;
    repeat (5) @(posedge clk); #1;
  endtask

  task automatic test_single_frame();
    int fe0, ov0, w;
    logic [7:0] e;
    fe0 = fe_cnt; ov0 = ov_cnt;
    exp_q.push_back(8'hA5);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(e_bit(8'hA5, i));
    line = 1'b1;
    // Stop sample lands on the edge HALF+2 cycles into the stop bit
    repeat (CPB / 2 + 2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (valid !== 1'b0) $display("FAIL single_early_valid: got %b want 0", valid); else n_pass++;
    @(negedge clk);
    n_checks++; if (valid !== 1'b1) $display("FAIL single_valid: got %b want 1", valid); else n_pass++;
    n_checks++; if (data !== exp_q[0]) $display("FAIL single_data: got %h want %h", data, exp_q[0]); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL single_busy: got %b want 0", busy); else n_pass++;
    repeat (CPB - CPB / 2 - 3) @(posedge clk); #1;
    n_checks++; if (fe_cnt != fe0) $display("FAIL single_ferr: got %0d pulses want 0", fe_cnt - fe0); else n_pass++;
    n_checks++; if (ov_cnt != ov0) $display("FAIL single_ovr: got %0d pulses want 0", ov_cnt - ov0); else n_pass++;
    ready = 1'b1;
    w = 0;
    @(negedge clk);
    while (valid !== 1'b1 && w < 6000) begin @(negedge clk); w++; end
    n_checks++;
    if (valid !== 1'b1 || exp_q.size() == 0) $display("FAIL single_pop: rx_valid=%b queued=%0d want a byte", valid, exp_q.size());
    else begin
      e = exp_q.pop_front();
      if (data !== e) $display("FAIL single_pop: got %h want %h", data, e); else n_pass++;
    end
    @(posedge clk); #1 ready = 1'b0;
    @(negedge clk);
    n_checks++; if (valid !== 1'b0) $display("FAIL single_empty: got %b want 0", valid); else n_pass++;
    @(posedge clk); #1;
  endtask

  function automatic logic e_bit(input logic [7:0] b, input int i);
    return b[i];
  endfunction

  task automatic test_back_to_back();
    int fe0, ov0, w;
    logic [7:0] e;
    fe0 = fe_cnt; ov0 = ov_cnt;
    send_frame(8'h00, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    send_frame(8'h3C, 1'b1, 1'b1);
    ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      w = 0;
      @(negedge clk);
      while (valid !== 1'b1 && w < 6000) begin @(negedge clk); w++; end
      n_checks++;
      if (valid !== 1'b1 || exp_q.size() == 0) $display("FAIL b2b_pop%0d: rx_valid=%b queued=%0d want a byte", k, valid, exp_q.size());
      else begin
        e = exp_q.pop_front();
        if (data !== e) $display("FAIL b2b_pop%0d: got %h want %h", k, data, e); else n_pass++;
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_checks++; if (valid !== 1'b0) $display("FAIL b2b_empty: got %b want 0", valid); else n_pass++;
    @(posedge clk); #1 ready = 1'b0;
    n_checks++; if (fe_cnt != fe0 || ov_cnt != ov0) $display("FAIL b2b_errs: ferr %0d ovr %0d pulses want 0", fe_cnt - fe0, ov_cnt - ov0); else n_pass++;
  endtask

  task automatic test_frame_error();
    int fe0, ov0;
    fe0 = fe_cnt; ov0 = ov_cnt;
    send_frame(8'h55, 1'b0, 1'b0);
    repeat (600) @(posedge clk); #1;
    n_checks++; if (fe_cnt - fe0 != 1) $display("FAIL ferr_pulse: got %0d cycles want 1", fe_cnt - fe0); else n_pass++;
    n_checks++; if (valid !== 1'b0) $display("FAIL ferr_valid: got %b want 0", valid); else n_pass++;
    n_checks++; if (ov_cnt != ov0) $display("FAIL ferr_ovr: got %0d pulses want 0", ov_cnt - ov0); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL ferr_busy: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_glitch();
    int fe0;
    fe0 = fe_cnt;
    line = 1'b0;
    repeat (50) @(posedge clk);
    @(negedge clk);
    n_checks++; if (busy !== 1'b1) $display("FAIL glitch_start: rx_busy=%b want 1", busy); else n_pass++;
    repeat (50) @(posedge clk); #1 line = 1'b1;
    repeat (121) @(posedge clk);
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL glitch_abort: rx_busy=%b want 0", busy); else n_pass++;
    repeat (400) @(posedge clk); #1;
    n_checks++; if (valid !== 1'b0 || fe_cnt != fe0) $display("FAIL glitch_quiet: rx_valid=%b ferr=%0d want 0/0", valid, fe_cnt - fe0); else n_pass++;
  endtask

  task automatic test_overrun();
    int ov0, w;
    logic [7:0] e;
    ov0 = ov_cnt;
    ready = 1'b0;
    for (int v = 1; v <= 5; v++) send_frame(8'(v), 1'b1, (v <= 4) ? 1'b1 : 1'b0);
    repeat (10) @(posedge clk); #1;
    n_checks++; if (ov_cnt - ov0 != 1) $display("FAIL ovr_pulse: got %0d cycles want 1", ov_cnt - ov0); else n_pass++;
    n_checks++; if (valid !== 1'b1 || data !== 8'h01) $display("FAIL ovr_head: valid=%b data=%h want 1/01", valid, data); else n_pass++;
    // Pop exactly on the cycle the 6th byte is pushed into the full FIFO
    fork
      send_frame(8'h06, 1'b1, 1'b1);
      begin
        repeat (9 * CPB + CPB / 2 + 2) @(posedge clk);
        #1 ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (valid !== 1'b1 || exp_q.size() == 0) $display("FAIL ovr_swap_pop: rx_valid=%b want 1", valid);
        else begin
          e = exp_q.pop_front();
          if (data !== e) $display("FAIL ovr_swap_pop: got %h want %h", data, e); else n_pass++;
        end
        @(posedge clk); #1 ready = 1'b0;
      end
    join
    n_checks++; if (ov_cnt - ov0 != 1) $display("FAIL ovr_swap: got %0d cycles want 1 total", ov_cnt - ov0); else n_pass++;
    ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      w = 0;
      @(negedge clk);
      while (valid !== 1'b1 && w < 6000) begin @(negedge clk); w++; end
      n_checks++;
      if (valid !== 1'b1 || exp_q.size() == 0) $display("FAIL ovr_pop%0d: rx_valid=%b queued=%0d want a byte", k, valid, exp_q.size());
      else begin
        e = exp_q.pop_front();
        if (data !== e) $display("FAIL ovr_pop%0d: got %h want %h", k, data, e); else n_pass++;
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_checks++; if (valid !== 1'b0) $display("FAIL ovr_empty: got %b want 0", valid); else n_pass++;
    @(posedge clk); #1 ready = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    int fe0, ov0, w;
    logic [7:0] e;
    ready = 1'b0;
    send_frame(8'h99, 1'b1, 1'b1);
    repeat (5) @(posedge clk); #1;
    n_checks++; if (valid !== 1'b1) $display("FAIL rstmid_pre: rx_valid=%b want 1", valid); else n_pass++;
    fork
      send_frame(8'h81, 1'b1, 1'b0);
      begin
        repeat (1500) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++; if (valid !== 1'b0) $display("FAIL rstmid_valid: got %b want 0", valid); else n_pass++;
        n_checks++; if (data !== 8'h00) $display("FAIL rstmid_data: got %h want 00", data); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (ferr !== 1'b0 || ovr !== 1'b0) $display("FAIL rstmid_errs: ferr=%b ovr=%b want 0/0", ferr, ovr); else n_pass++;
      end
    join
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    fe0 = fe_cnt; ov0 = ov_cnt;
    repeat (20) @(posedge clk); #1;
    send_frame(8'h42, 1'b1, 1'b1);
    ready = 1'b1;
    w = 0;
    @(negedge clk);
    while (valid !== 1'b1 && w < 6000) begin @(negedge clk); w++; end
    n_checks++;
    if (valid !== 1'b1 || exp_q.size() == 0) $display("FAIL rstmid_next: rx_valid=%b queued=%0d want a byte", valid, exp_q.size());
    else begin
      e = exp_q.pop_front();
      if (data !== e) $display("FAIL rstmid_next: got %h want %h", data, e); else n_pass++;
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (valid !== 1'b0) $display("FAIL rstmid_empty: got %b want 0", valid); else n_pass++;
    n_checks++; if (fe_cnt != fe0 || ov_cnt != ov0) $display("FAIL rstmid_errs2: ferr %0d ovr %0d pulses want 0", fe_cnt - fe0, ov_cnt - ov0); else n_pass++;
    @(posedge clk); #1 ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_frame_error();
    test_glitch();
    test_overrun();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Runaway guard
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
